// File: rtl/rds_pkg.sv
// -----------------------------------------------------------------------------
// rds_pkg
// Shared declarations for the RDS pair scheduler slice.
//   - RDS_SAMPLE_W  : default sample width of the RDS filter chain outputs
//   - sched_state_t : pairing scheduler state (SYNC / RUN / FLUSH)
//   - sat_inc16     : saturating 16-bit increment used by event counters
// -----------------------------------------------------------------------------
package rds_pkg;

  localparam int RDS_SAMPLE_W = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rds_sample_fifo.sv
// -----------------------------------------------------------------------------
// rds_sample_fifo
// Single-clock synchronous FIFO holding samples of one RDS channel.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write strobe and sample; ignored when full unless a
//                       pop happens in the same cycle
//   pop               : remove the head entry (ignored when empty)
//   clear             : synchronous flush of all entries
//   head_data         : entry at the read pointer (valid when !empty)
//   full, empty, count: occupancy status, count is $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module rds_sample_fifo
  import rds_pkg::*;
#(
  parameter int DW    = RDS_SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; clear has priority.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_ok_s  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    push_ok_s = push && (!full || pop_ok_s);
    if (clear) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rds_pair_scheduler.sv
// -----------------------------------------------------------------------------
// rds_pair_scheduler
// Pairs samples of two free-running RDS filter outputs (A: 57 kHz band-pass of
// the FM baseband, B: tripled-pilot 57 kHz carrier) and streams aligned {B,A}
// pairs on an AXI-Stream master. Per-channel FIFOs absorb source skew; any
// overflow flushes both channels and re-aligns on the next joint strobe.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   a_data, a_valid       : channel A sample and 1-cycle strobe (no ready)
//   b_data, b_valid       : channel B sample and 1-cycle strobe (no ready)
//   m_tdata               : {B,A}, A in [DW-1:0]
//   m_tvalid, m_tready    : AXIS handshake
//   m_tlast               : last pair of each FRAME_LEN-pair frame
//   resync_pulse          : 1-cycle pulse for every overflow-triggered resync
//   drop_count            : saturating count of resync events
// -----------------------------------------------------------------------------
module rds_pair_scheduler
  import rds_pkg::*;
#(
  parameter int DW        = RDS_SAMPLE_W,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     a_data,
  input  logic              a_valid,
  input  logic [DW-1:0]     b_data,
  input  logic              b_valid,
  output logic [2*DW-1:0]   m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              resync_pulse,
  output logic [15:0]       drop_count
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCW-1:0] LAST_IDX = FCW'(FRAME_LEN - 1);

  sched_state_t     state_q, state_d;
  logic [2*DW-1:0]  m_tdata_q, m_tdata_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tlast_q, m_tlast_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic             resync_pulse_q, resync_pulse_d;
  logic [15:0]      drop_count_q, drop_count_d;

  logic             a_push_s, b_push_s;
  logic             pop_s;
  logic             fifo_clear_s;
  logic             a_ovf_s, b_ovf_s;
  logic [DW-1:0]    a_head_s, b_head_s;
  logic             a_full_s, b_full_s;
  logic             a_empty_s, b_empty_s;
  logic [CW-1:0]    a_count_s, b_count_s;

  rds_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (a_push_s),
    .push_data (a_data),
    .pop       (pop_s),
    .clear     (fifo_clear_s),
    .head_data (a_head_s),
    .full      (a_full_s),
    .empty     (a_empty_s),
    .count     (a_count_s)
  );

  rds_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (b_push_s),
    .push_data (b_data),
    .pop       (pop_s),
    .clear     (fifo_clear_s),
    .head_data (b_head_s),
    .full      (b_full_s),
    .empty     (b_empty_s),
    .count     (b_count_s)
  );

  // Scheduler FSM next state, pair pop, output register and counters.
  always_comb begin
    state_d        = state_q;
    m_tdata_d      = m_tdata_q;
    m_tvalid_d     = m_tvalid_q;
    m_tlast_d      = m_tlast_q;
    frame_cnt_d    = frame_cnt_q;
    resync_pulse_d = 1'b0;
    drop_count_d   = drop_count_q;
    a_push_s       = 1'b0;
    b_push_s       = 1'b0;
    pop_s          = 1'b0;
    fifo_clear_s   = 1'b0;
    a_ovf_s        = 1'b0;
    b_ovf_s        = 1'b0;

    case (state_q)
      SYNC: begin
        // Alignment point: only a joint strobe starts a new pairing epoch.
        if (a_valid && b_valid) begin
          a_push_s = 1'b1;
          b_push_s = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = SYNC;
        end
      end

      RUN: begin
        pop_s = !a_empty_s && !b_empty_s && (!m_tvalid_q || m_tready);
        // Full flag and count are both consulted so a corrupted status bit
        // still forces a resync instead of silently losing alignment.
        a_ovf_s  = a_valid && !pop_s && (a_full_s || (a_count_s >= CW'(DEPTH)));
        b_ovf_s  = b_valid && !pop_s && (b_full_s || (b_count_s >= CW'(DEPTH)));
        a_push_s = a_valid && !a_ovf_s;
        b_push_s = b_valid && !b_ovf_s;

        if (pop_s) begin
          m_tdata_d  = {b_head_s, a_head_s};
          m_tvalid_d = 1'b1;
          m_tlast_d  = (frame_cnt_q == LAST_IDX);
          if (frame_cnt_q == LAST_IDX) begin
            frame_cnt_d = {FCW{1'b0}};
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end else if (m_tvalid_q && m_tready) begin
          m_tvalid_d = 1'b0;
        end else begin
          m_tvalid_d = m_tvalid_q;
        end

        // Overflow on either or both channels yields one flush.
        if (a_ovf_s || b_ovf_s) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end

      FLUSH: begin
        // Any held pair is abandoned here; inputs this cycle are dropped.
        fifo_clear_s   = 1'b1;
        frame_cnt_d    = {FCW{1'b0}};
        m_tvalid_d     = 1'b0;
        resync_pulse_d = 1'b1;
        drop_count_d   = sat_inc16(drop_count_q);
        state_d        = SYNC;
      end

      default: begin
        fifo_clear_s = 1'b1;
        m_tvalid_d   = 1'b0;
        frame_cnt_d  = {FCW{1'b0}};
        state_d      = SYNC;
      end
    endcase
  end

  // Registered state and outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SYNC;
      m_tdata_q      <= {(2*DW){1'b0}};
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      frame_cnt_q    <= {FCW{1'b0}};
      resync_pulse_q <= 1'b0;
      drop_count_q   <= 16'd0;
    end else begin
      state_q        <= state_d;
      m_tdata_q      <= m_tdata_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tlast_q      <= m_tlast_d;
      frame_cnt_q    <= frame_cnt_d;
      resync_pulse_q <= resync_pulse_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign m_tdata      = m_tdata_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tlast      = m_tlast_q;
  assign resync_pulse = resync_pulse_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_rds_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rds_pair_scheduler
// Directed + random bench for rds_pair_scheduler (DW=32, DEPTH=8, FRAME_LEN=4).
// A behavioural model of the pairing rules produces expected pairs into a
// scoreboard queue; each output handshake pops and compares. AXIS hold
// stability, tvalid, resync_pulse and drop_count are compared every cycle.
// -----------------------------------------------------------------------------
module tb_rds_pair_scheduler;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int M_SYNC  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [DW-1:0]   a_data = '0;
  logic            a_valid = 1'b0;
  logic [DW-1:0]   b_data = '0;
  logic            b_valid = 1'b0;
  logic [2*DW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready = 1'b0;
  logic            resync_pulse;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  rds_pair_scheduler #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a_data       (a_data),
    .a_valid      (a_valid),
    .b_data       (b_data),
    .b_valid      (b_valid),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .resync_pulse (resync_pulse),
    .drop_count   (drop_count)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit            model_ok = 1'b0;
  bit            post_rst = 1'b0;
  int            ms = M_SYNC;
  logic [31:0]   qa[$];
  logic [31:0]   qb[$];
  logic [63:0]   exp_data_q[$];
  bit            exp_last_q[$];
  bit            mv = 1'b0;
  int            fc = 0;
  int            dc = 0;
  bit            rp = 1'b0;

  // AXIS hold tracking and observed event counters
  bit            hold_prev = 1'b0;
  logic [63:0]   prev_data;
  logic          prev_last;
  int            hs_cnt = 0;
  int            last_cnt = 0;
  int            pulse_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit av, input logic [31:0] ad,
                            input bit bv, input logic [31:0] bd, input bit rdy);
    bit pop, hs, ova, ovb;
    logic [31:0] ha, hb;
    if (rst) begin
      ms = M_SYNC; qa.delete(); qb.delete();
      exp_data_q.delete(); exp_last_q.delete();
      mv = 1'b0; fc = 0; dc = 0; rp = 1'b0;
      post_rst = 1'b1; model_ok = 1'b1;
      return;
    end
    post_rst = 1'b0;
    hs  = mv && rdy;
    pop = (ms == M_RUN) && (qa.size() > 0) && (qb.size() > 0) && (!mv || rdy);
    case (ms)
      M_SYNC: begin
        rp = 1'b0;
        if (av && bv) begin
          qa.push_back(ad); qb.push_back(bd); ms = M_RUN;
        end
      end
      M_RUN: begin
        rp  = 1'b0;
        ova = av && (qa.size() == DEPTH) && !pop;
        ovb = bv && (qb.size() == DEPTH) && !pop;
        if (pop) begin
          ha = qa.pop_front(); hb = qb.pop_front();
          exp_data_q.push_back({hb, ha});
          exp_last_q.push_back(fc == FL - 1);
          mv = 1'b1;
          fc = (fc == FL - 1) ? 0 : fc + 1;
        end else if (hs) begin
          mv = 1'b0;
        end
        if (av && !ova) qa.push_back(ad);
        if (bv && !ovb) qb.push_back(bd);
        if (ova || ovb) ms = M_FLUSH;
      end
      default: begin
        if (mv && !rdy && exp_data_q.size() != 0) begin
          void'(exp_data_q.pop_front()); void'(exp_last_q.pop_front());
        end
        qa.delete(); qb.delete();
        fc = 0; mv = 1'b0; rp = 1'b1;
        if (dc < 65535) dc++;
        ms = M_SYNC;
      end
    endcase
  endtask

  // One clock cycle: drive at negedge, compare registered outputs, advance model.
  task automatic cyc(input bit rst, input bit av, input logic [31:0] ad,
                     input bit bv, input logic [31:0] bd, input bit rdy);
    logic [63:0] ed;
    bit el;
    @(negedge clk);
    reset = rst; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; m_tready = rdy;
    if (model_ok) begin
      check("tvalid", 64'(m_tvalid), 64'(mv));
      check("resync_pulse", 64'(resync_pulse), 64'(rp));
      check("drop_count", 64'(drop_count), 64'(dc));
      if (post_rst) begin
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
      end
      if (hold_prev) begin
        check("axis_hold_valid", 64'(m_tvalid), 64'd1);
        check("axis_hold_data", m_tdata, prev_data);
        check("axis_hold_last", 64'(m_tlast), 64'(prev_last));
      end
      if (mv && rdy) begin
        check("sb_avail", 64'(exp_data_q.size() != 0), 64'd1);
        if (exp_data_q.size() != 0) begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          check("pair_data", m_tdata, ed);
          check("pair_last", 64'(m_tlast), 64'(el));
        end
      end
    end
    if (m_tvalid === 1'b1 && rdy) begin
      hs_cnt++;
      if (m_tlast === 1'b1) last_cnt++;
    end
    if (resync_pulse === 1'b1) pulse_cnt++;
    hold_prev = model_ok && mv && !rdy && (ms != M_FLUSH) && !rst;
    prev_data = m_tdata;
    prev_last = m_tlast;
    model_step(rst, av, ad, bv, bd, rdy);
    @(posedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
  endtask

  task automatic joint(input int k, input bit rdy);
    cyc(1'b0, 1'b1, 32'(k), 1'b1, 32'(k + 1000), rdy);
  endtask

  initial begin
    int h0, l0, p0;

    // 1: joint strobes every 4th cycle, ready high
    do_reset();
    #1;
    check("t1_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("t1_rst_tdata", m_tdata, 64'd0);
    check("t1_rst_drops", 64'(drop_count), 64'd0);
    h0 = hs_cnt;
    joint(0, 1'b1);
    #1 check("t1_lat_cycle1", 64'(m_tvalid), 64'd0);
    idle(1, 1'b1);
    #1 check("t1_lat_cycle2", 64'(m_tvalid), 64'd1);
    check("t1_first_pair", m_tdata, {32'd1000, 32'd0});
    idle(2, 1'b1);
    for (int k = 1; k < 8; k++) begin
      joint(k, 1'b1);
      idle(3, 1'b1);
    end
    check("t1_pairs", 64'(hs_cnt - h0), 64'd8);
    check("t1_drops", 64'(drop_count), 64'd0);

    // 2: B lags A by 3 strobes, FRAME_LEN=4
    do_reset();
    h0 = hs_cnt; l0 = last_cnt; p0 = pulse_cnt;
    joint(0, 1'b1);
    for (int k = 1; k < 4; k++) cyc(1'b0, 1'b1, 32'(k), 1'b0, 32'd0, 1'b1);
    for (int k = 4; k < 14; k++) cyc(1'b0, 1'b1, 32'(k), 1'b1, 32'(k - 3 + 1000), 1'b1);
    for (int k = 11; k < 14; k++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'(k + 1000), 1'b1);
    idle(6, 1'b1);
    check("t2_pairs", 64'(hs_cnt - h0), 64'd14);
    check("t2_tlasts", 64'(last_cnt - l0), 64'd3);
    check("t2_no_resync", 64'(pulse_cnt - p0), 64'd0);

    // 3: stall while both channels push until overflow
    do_reset();
    p0 = pulse_cnt;
    for (int k = 0; k < 10; k++) joint(k, 1'b0);
    idle(4, 1'b0);
    #1;
    check("t3_pulses", 64'(pulse_cnt - p0), 64'd1);
    check("t3_drops", 64'(drop_count), 64'd1);
    check("t3_tvalid_low", 64'(m_tvalid), 64'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 32'(50 + k), 1'b0, 32'd0, 1'b1);
    #1 check("t3_sync_waits", 64'(m_tvalid), 64'd0);
    h0 = hs_cnt;
    joint(77, 1'b1);
    idle(3, 1'b1);
    check("t3_resync_pair", 64'(hs_cnt - h0), 64'd1);

    // 4: full FIFOs, push in same cycle as pop
    do_reset();
    h0 = hs_cnt;
    for (int k = 0; k < 9; k++) joint(k, 1'b0);
    for (int k = 9; k < 15; k++) joint(k, 1'b1);
    idle(12, 1'b1);
    check("t4_pairs", 64'(hs_cnt - h0), 64'd15);
    check("t4_drops", 64'(drop_count), 64'd0);

    // 5: reset while stalled mid-frame
    do_reset();
    for (int k = 0; k < 6; k++) joint(k, 1'b1);
    idle(2, 1'b0);
    #1 check("t5_stalled", 64'(m_tvalid), 64'd1);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #1;
    check("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_rst_tdata", m_tdata, 64'd0);
    check("t5_rst_tlast", 64'(m_tlast), 64'd0);
    check("t5_rst_pulse", 64'(resync_pulse), 64'd0);
    h0 = hs_cnt; l0 = last_cnt;
    for (int k = 100; k < 108; k++) joint(k, 1'b1);
    idle(4, 1'b1);
    check("t5_pairs", 64'(hs_cnt - h0), 64'd8);
    check("t5_tlasts", 64'(last_cnt - l0), 64'd2);

    // 6: random valids and ready
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 3) != 0));
    end
    idle(20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
